// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset core: sequences each instruction
// and drives datapath selects/enables, with memory-wait timeout and illegal-opcode flags.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory completes
// DECODE | read regs, precompute branch target in ALUOut
// MEMADR | compute load/store address rs + imm
// MEMRD  | read data memory at ALUOut
// MEMWB  | write MDR to rt
// MEMWR  | write rt to memory at ALUOut
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | compare rs/rt, load PC from ALUOut when equal
// JUMP   | load PC with jump target
// IMMEXE | immediate ALU operation (ADDI/ORI/LUI)
// IMMWB  | write ALUOut to rt
module mc_main_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       SigHigh,
    output logic       bus_err,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, JUMP, IMMEXE, IMMWB
    } state_t;

    state_t     state, nextState;
    logic [7:0] waitCnt, nextWait;
    logic       timeout;

    // The zero flag qualifies the PC load in the datapath through PCWriteCond.
    logic unusedZero;
    assign unusedZero = zero;

    assign timeout = (waitCnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            waitCnt <= 8'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWait;
        end
    end

    always_comb begin
        nextState   = state;
        nextWait    = 8'd0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        SigHigh     = 1'b0;
        bus_err     = 1'b0;
        illegal_op  = 1'b0;

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    nextState = DECODE;
                end else if (timeout) begin
                    bus_err   = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextWait  = waitCnt + 8'd1;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (op_code)
                    OP_LW, OP_SW:             nextState = MEMADR;
                    OP_RTYPE:                 nextState = EXEC;
                    OP_BEQ:                   nextState = BRANCH;
                    OP_J:                     nextState = JUMP;
                    OP_ADDI, OP_ORI, OP_LUI:  nextState = IMMEXE;
                    default: begin
                        illegal_op = 1'b1;
                        nextState  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nextState = (op_code == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    nextState = MEMWB;
                end else if (timeout) begin
                    bus_err   = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextWait  = waitCnt + 8'd1;
                end
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                nextState = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    nextState = FETCH;
                end else if (timeout) begin
                    bus_err   = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextWait  = waitCnt + 8'd1;
                end
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nextState   = FETCH;
            end
            JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                nextState = FETCH;
            end
            IMMEXE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = (op_code == OP_ORI) ? 2'b11 : 2'b00;
                SigHigh   = (op_code == OP_LUI);
                nextState = IMMWB;
            end
            IMMWB: begin
                RegWrite  = 1'b1;
                SigHigh   = (op_code == OP_LUI);
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase

        // Reset silences every enable in the same cycle so an aborted access never writes.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            SigHigh     = 1'b0;
            bus_err     = 1'b0;
            illegal_op  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: per-instruction step lists with random memory wait states,
// compared every cycle against the expected control word.
module tb_mc_main_ctrl;

    localparam int TO = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // step kinds of an instruction as listed in the behaviour description
    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5,
                   S_EX = 6, S_AWB = 7, S_BR = 8, S_J = 9, S_IE = 10, S_IW = 11;

    typedef struct packed {
        logic       pcW, pcWC, iorD, memR, memW, irW, m2r, regDst, regW, srcA;
        logic [1:0] srcB, aluOp, pcSrc;
        logic       sigH, busErr, illOp;
    } ctl_t;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] op_code;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic       RegDst, RegWrite, ALUSrcA, SigHigh, bus_err, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;

    mc_main_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .SigHigh(SigHigh), .bus_err(bus_err), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    logic [5:0] legalOps [8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_LUI};

    int         seq[$];
    int         idx;
    int         waitN;
    logic [5:0] curOp;
    logic [5:0] forceOp;
    bit         forceValid = 0;

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legalOps[i]) if (legalOps[i] == op) return 1;
        return 0;
    endfunction

    function automatic string step_name(input int s);
        case (s)
            S_F: return "fetch";    S_D: return "decode";  S_MA: return "memadr";
            S_MR: return "memrd";   S_MWB: return "memwb"; S_MW: return "memwr";
            S_EX: return "exec";    S_AWB: return "aluwb"; S_BR: return "branch";
            S_J: return "jump";     S_IE: return "immexe"; default: return "immwb";
        endcase
    endfunction

    task automatic new_instr();
        logic [5:0] op;
        if (forceValid) begin
            op = forceOp;
            forceValid = 0;
        end else if ($urandom_range(0, 9) != 0) begin
            op = legalOps[$urandom_range(0, 7)];
        end else begin
            do op = 6'($urandom); while (is_legal(op));
        end
        curOp = op;
        idx   = 0;
        waitN = 0;
        seq   = '{S_F, S_D};
        case (op)
            OP_LW:                   seq = {seq, S_MA, S_MR, S_MWB};
            OP_SW:                   seq = {seq, S_MA, S_MW};
            OP_RTYPE:                seq = {seq, S_EX, S_AWB};
            OP_BEQ:                  seq = {seq, S_BR};
            OP_J:                    seq = {seq, S_J};
            OP_ADDI, OP_ORI, OP_LUI: seq = {seq, S_IE, S_IW};
            default: ;
        endcase
    endtask

    task automatic start_op(input logic [5:0] op);
        forceOp = op;
        forceValid = 1;
        new_instr();
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step_cycle(input logic r, input logic rdy);
        ctl_t exp, got;
        int   s;
        bit   adv, abort;
        rst       = r;
        mem_ready = rdy;
        zero      = 1'($urandom);
        op_code   = (idx == 0) ? 6'($urandom) : curOp;
        @(negedge clk);
        s = seq[idx];
        exp = '0;
        adv = 0;
        abort = 0;
        case (s)
            S_F, S_MR, S_MW: begin
                if (s == S_F) begin exp.memR = 1; exp.srcB = 2'b01; end
                if (s == S_MR) begin exp.memR = 1; exp.iorD = 1; end
                if (s == S_MW) begin exp.memW = 1; exp.iorD = 1; end
                if (rdy) begin
                    if (s == S_F) begin exp.irW = 1; exp.pcW = 1; end
                    adv = 1;
                end else if (waitN + 1 == TO) begin
                    exp.busErr = 1;
                    abort = 1;
                end
            end
            S_D: begin
                exp.srcB = 2'b11;
                exp.illOp = !is_legal(curOp);
                adv = 1;
            end
            S_MA:  begin exp.srcA = 1; exp.srcB = 2'b10; adv = 1; end
            S_MWB: begin exp.regW = 1; exp.m2r = 1; adv = 1; end
            S_EX:  begin exp.srcA = 1; exp.aluOp = 2'b10; adv = 1; end
            S_AWB: begin exp.regW = 1; exp.regDst = 1; adv = 1; end
            S_BR: begin
                exp.srcA = 1; exp.aluOp = 2'b01; exp.pcWC = 1; exp.pcSrc = 2'b01; adv = 1;
            end
            S_J:   begin exp.pcW = 1; exp.pcSrc = 2'b10; adv = 1; end
            S_IE: begin
                exp.srcA = 1; exp.srcB = 2'b10;
                exp.aluOp = (curOp == OP_ORI) ? 2'b11 : 2'b00;
                exp.sigH = (curOp == OP_LUI);
                adv = 1;
            end
            default: begin exp.regW = 1; exp.sigH = (curOp == OP_LUI); adv = 1; end
        endcase
        if (r) exp = '0;
        got = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, SigHigh, bus_err, illegal_op};
        check(r ? "reset" : step_name(s), 32'(got), 32'(exp));
        if (r || abort) begin
            new_instr();
        end else if (adv) begin
            waitN = 0;
            idx++;
            if (idx == seq.size()) new_instr();
        end else begin
            waitN++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_instr(input logic [5:0] op);
        start_op(op);
        repeat (seq.size()) step_cycle(0, 1);
    endtask

    initial begin
        int pct;
        rst = 1; mem_ready = 0; zero = 0; op_code = '0;
        new_instr();
        @(posedge clk);
        #1;
        step_cycle(1, 0);
        step_cycle(1, 1);

        // zero wait-state latency of every opcode plus an illegal one
        run_instr(OP_LW);
        run_instr(OP_LUI);
        run_instr(OP_BEQ);
        run_instr(6'b111111);
        run_instr(OP_RTYPE);
        run_instr(OP_SW);
        run_instr(OP_J);
        run_instr(OP_ADDI);
        run_instr(OP_ORI);

        // fetch timeout, then ready arriving on the last allowed wait cycle
        start_op(OP_RTYPE);
        repeat (TO) step_cycle(0, 0);
        start_op(OP_RTYPE);
        repeat (TO - 1) step_cycle(0, 0);
        step_cycle(0, 1);
        repeat (seq.size() - 1) step_cycle(0, 1);

        // load and store timeouts in the data access
        start_op(OP_LW);
        repeat (3) step_cycle(0, 1);
        repeat (TO) step_cycle(0, 0);
        start_op(OP_SW);
        repeat (3) step_cycle(0, 1);
        repeat (TO) step_cycle(0, 0);

        // reset in the middle of a load read
        start_op(OP_LW);
        repeat (3) step_cycle(0, 1);
        step_cycle(1, 0);
        step_cycle(1, 0);
        run_instr(OP_LW);

        // random traffic alternating fast and slow memory
        for (int blk = 0; blk < 30; blk++) begin
            pct = (blk % 3 == 2) ? 15 : 75;
            for (int i = 0; i < 100; i++)
                step_cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < pct));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS-subset CPU core.
- Sequences fetch/decode/execute/memory/writeback and drives all datapath mux selects, write enables and ALUOp.
- Supplies SigHigh for LUI so the immediate path shifts the immediate into the upper half.
- Waits on a memory ready handshake; flags memory timeouts and illegal opcodes.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles in any memory state before bus error (range 1..255).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- op_code  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by zero (BEQ).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  write register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- SigHigh  out  1  LUI upper-immediate select.
- bus_err  out  1  one-cycle pulse on memory timeout.
- illegal_op  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, ORI 001101, LUI 001111.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, IMMEXE, IMMWB.
- Reset:
  - rst=1 forces state to FETCH and wait counter to 0 on the next edge.
  - All outputs are 0 while rst is high.
  - Reset mid-instruction aborts with no further write enables.
- Outputs are Moore (decoded from state) except the handshake-qualified enables below. All unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; go to DECODE in that cycle, otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op_code:
  - LW/SW -> MEMADR.
  - RTYPE -> EXEC.
  - BEQ -> BRANCH.
  - J -> JUMP.
  - ADDI/ORI/LUI -> IMMEXE.
  - Any other opcode -> FETCH with illegal_op=1 for one cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- IMMEXE: ALUSrcA=1, ALUSrcB=10.
  - ALUOp=11 for ORI, 00 otherwise.
  - SigHigh=1 for LUI only.
  - Go to IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0; SigHigh held as in IMMEXE. Go to FETCH.
- Opcode source: op_code is sampled every cycle; the IR is stable after DECODE.
- Wait counter (8 bit):
  - Counts consecutive cycles in FETCH/MEMRD/MEMWR with mem_ready=0; clears on state exit.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: bus_err=1 for one cycle, drop the access, go to FETCH.
  - No IRWrite, PCWrite or RegWrite is issued for the dropped access.
  - mem_ready=1 in the same cycle as the timeout takes priority: normal completion, no bus_err.
- Latency with zero wait states (mem_ready tied 1):
  - RTYPE, SW, ADDI, ORI, LUI: 4 cycles.
  - LW: 5 cycles.
  - BEQ, J: 3 cycles.

Test Plan:
- rst=1 for 2 cycles mid-MEMRD -> all outputs 0 during reset; first post-reset cycle is FETCH with MemRead=1, IorD=0, ALUSrcB=01, no RegWrite ever issued for the aborted LW.
- mem_ready=1, op_code=100011 (LW) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=1 exactly in cycle 5.
- op_code=001111 (LUI) -> SigHigh=1 in IMMEXE and IMMWB, ALUSrcB=10, ALUOp=00, RegWrite=1 in cycle 4; SigHigh=0 in all other states.
- op_code=000100 (BEQ), zero=1 -> PCWriteCond=1, PCSource=01, ALUOp=01 in cycle 3; back in FETCH in cycle 4.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err pulses once after 4 wait cycles, no IRWrite/PCWrite, FETCH restarts; repeat with mem_ready=1 on the 4th cycle -> no bus_err, IRWrite=1.
- op_code=111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite/PCWrite beyond the fetch.
